// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock checkers.
// Contents:
//   mon_state_e  - monitor FSM state (2-bit encoding)
//   DefCntW      - default period/high-time counter width
//   DefLockCnt   - default number of consecutive good periods needed for lock
//   sat_max()    - all-ones value for a counter of the given width
package clk_div_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitEdge = 2'd1,
    StMeasure  = 2'd2,
    StLocked   = 2'd3
  } mon_state_e;

  localparam int unsigned DefCntW    = 8;
  localparam int unsigned DefLockCnt = 4;

  // Saturation value of a width-bit counter; width must be below 32.
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/clk_edge_detect.sv
// Rise/fall detector for a clock-derived signal launched from a `clk` flop.
// Edges are decoded combinationally against a one-cycle registered copy, so
// they are visible in the same cycle the new level is sampled.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-high reset
//   i_div_clk - divided clock under test
//   o_rise    - i_div_clk is 1 and was 0 last cycle
//   o_fall    - i_div_clk is 0 and was 1 last cycle
module clk_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_div_clk,
  output logic o_rise,
  output logic o_fall
);

  logic div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= 1'b0;
    end else begin
      div_q <= i_div_clk;
    end
  end

  assign o_rise = i_div_clk & ~div_q;
  assign o_fall = ~i_div_clk & div_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Consumer-side checker for counter-generated divided clocks.
// Measures the period and high time of i_div_clk in `clk` cycles, declares
// lock after LOCK_CNT consecutive periods equal to i_expected_ratio, and
// raises sticky flags on a ratio mismatch while locked or on loss of edges.
// Ports:
//   clk              - system clock the divided clock is derived from
//   reset            - asynchronous active-high reset
//   i_en             - monitor enable
//   i_div_clk        - divided clock under test
//   i_expected_ratio - expected period in clk cycles (>= 2, stable while enabled)
//   i_err_clr        - clears sticky flags (a same-cycle set wins)
//   o_period         - last measured period
//   o_high_time      - last measured high time
//   o_period_valid   - one-cycle pulse aligned with an o_period update
//   o_locked         - ratio lock status
//   o_ratio_err      - sticky: mismatch seen while locked
//   o_timeout        - sticky: counter saturated without a rising edge
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned LOCK_CNT = DefLockCnt
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_div_clk,
  input  logic [CNT_W-1:0] i_expected_ratio,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_ratio_err,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(sat_max(CNT_W));
  localparam logic [3:0]       LockCnt = 4'(LOCK_CNT);

  logic rise, fall;

  clk_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .i_div_clk(i_div_clk),
    .o_rise   (rise),
    .o_fall   (fall)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             ratio_err_q, ratio_err_d;
  logic             timeout_q, timeout_d;

  logic cnt_sat;
  logic ratio_match;
  logic [3:0] match_inc;

  assign cnt_sat     = (cnt_q == CntMax);
  assign ratio_match = (cnt_q == i_expected_ratio);
  assign match_inc   = match_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    // Counter runs freely; a rise restarts it at 1 so it reads the period on the next rise.
    cnt_d       = rise ? CNT_W'(1) : (cnt_sat ? cnt_q : cnt_q + CNT_W'(1));
    match_d     = match_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    ratio_err_d = ratio_err_q & ~i_err_clr;
    timeout_d   = timeout_q & ~i_err_clr;

    if (!i_en) begin
      state_d  = StIdle;
      cnt_d    = '0;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          match_d = '0;
          if (i_expected_ratio >= CNT_W'(2)) begin
            state_d = StWaitEdge;
          end
        end
        StWaitEdge: begin
          // First edge only starts the counter; there is no prior period to report.
          if (rise) begin
            state_d = StMeasure;
          end
        end
        StMeasure, StLocked: begin
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            if (ratio_match) begin
              if (state_q == StMeasure) begin
                match_d = match_inc;
                if (match_inc >= LockCnt) begin
                  state_d  = StLocked;
                  locked_d = 1'b1;
                end
              end
            end else begin
              match_d = '0;
              if (state_q == StLocked) begin
                ratio_err_d = 1'b1;
                locked_d    = 1'b0;
                state_d     = StMeasure;
              end
            end
          end else if (cnt_sat) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            state_d   = StWaitEdge;
          end
          if (fall) begin
            high_d = cnt_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      match_q     <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      ratio_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      ratio_err_q <= ratio_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_period       = period_q;
  assign o_high_time    = high_q;
  assign o_period_valid = valid_q;
  assign o_locked       = locked_q;
  assign o_ratio_err    = ratio_err_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a scoreboard queue holds the expected
// period/high time for every rise that should be reported; the output monitor
// pops and compares on each o_period_valid pulse.
module tb_clk_div_monitor;
  import clk_div_pkg::*;

  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_en;
  logic            i_div_clk;
  logic [CntW-1:0] i_expected_ratio;
  logic            i_err_clr;
  logic [CntW-1:0] o_period;
  logic [CntW-1:0] o_high_time;
  logic            o_period_valid;
  logic            o_locked;
  logic            o_ratio_err;
  logic            o_timeout;

  clk_div_monitor #(
    .CNT_W   (CntW),
    .LOCK_CNT(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_en            (i_en),
    .i_div_clk       (i_div_clk),
    .i_expected_ratio(i_expected_ratio),
    .i_err_clr       (i_err_clr),
    .o_period        (o_period),
    .o_high_time     (o_high_time),
    .o_period_valid  (o_period_valid),
    .o_locked        (o_locked),
    .o_ratio_err     (o_ratio_err),
    .o_timeout       (o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fails = 0;
  bit   armed   = 1'b0;  // bench's view: the previous period is being measured
  int   last_h  = 0;
  int   last_l  = 0;
  bit   saw_lock = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One divided-clock period: rise now (at posedge+1), h cycles high, l low.
  // clr pulses i_err_clr during the cycle the rise is detected.
  task automatic drive_cycle(input int h, input int l, input bit clr);
    exp_t e;
    if (armed) begin
      e.period = last_h + last_l;
      e.high   = last_h;
      exp_q.push_back(e);
    end
    i_div_clk = 1'b1;
    i_err_clr = clr;
    @(posedge clk);
    #1;
    i_err_clr = 1'b0;
    repeat (h - 1) @(posedge clk);
    #1;
    i_div_clk = 1'b0;
    repeat (l) @(posedge clk);
    #1;
    last_h = h;
    last_l = l;
    armed  = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_locked) saw_lock = 1'b1;
    if (o_period_valid) begin
      check("sb_expected_report", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_period", 32'(o_period), 32'(e.period));
        check("sb_high_time", 32'(o_high_time), 32'(e.high));
      end
    end
  end

  initial begin
    reset            = 1'b1;
    i_en             = 1'b0;
    i_div_clk        = 1'b0;
    i_expected_ratio = 8'd8;
    i_err_clr        = 1'b0;
    #12;
    check("rst_period", 32'(o_period), 0);
    check("rst_high", 32'(o_high_time), 0);
    check("rst_valid", 32'(o_period_valid), 0);
    check("rst_locked", 32'(o_locked), 0);
    check("rst_ratio_err", 32'(o_ratio_err), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));

    @(posedge clk);
    #1;
    reset = 1'b0;
    i_en  = 1'b1;
    idle_cycles(3);

    // Ideal divide-by-8: lock on the 5th rise
    repeat (4) drive_cycle(4, 4, 1'b0);
    check("p1_not_locked_4", 32'(o_locked), 0);
    drive_cycle(4, 4, 1'b0);
    check("p1_locked_5", 32'(o_locked), 1);
    repeat (3) drive_cycle(4, 4, 1'b0);
    check("p1_ratio_err", 32'(o_ratio_err), 0);
    check("p1_timeout", 32'(o_timeout), 0);
    check("p1_period", 32'(o_period), 8);
    check("p1_high", 32'(o_high_time), 4);

    // One stretched low phase (period 9) while locked
    drive_cycle(4, 5, 1'b0);
    drive_cycle(4, 4, 1'b0);
    check("p2_period9", 32'(o_period), 9);
    check("p2_ratio_err", 32'(o_ratio_err), 1);
    check("p2_unlocked", 32'(o_locked), 0);
    repeat (3) drive_cycle(4, 4, 1'b0);
    check("p2_not_yet_relocked", 32'(o_locked), 0);
    drive_cycle(4, 4, 1'b0);
    check("p2_relocked", 32'(o_locked), 1);
    check("p2_err_sticky", 32'(o_ratio_err), 1);
    drive_cycle(4, 4, 1'b1);
    check("p2_err_cleared", 32'(o_ratio_err), 0);
    check("p2_still_locked", 32'(o_locked), 1);

    // Hold the divided clock low until the counter saturates
    armed = 1'b0;
    idle_cycles(200);
    check("p3_no_timeout_yet", 32'(o_timeout), 0);
    check("p3_locked_before", 32'(o_locked), 1);
    idle_cycles(60);
    check("p3_timeout", 32'(o_timeout), 1);
    check("p3_unlocked", 32'(o_locked), 0);
    check("p3_state", 32'(dut.state_q), 32'(StWaitEdge));
    repeat (5) drive_cycle(4, 4, 1'b0);
    check("p3_relocked", 32'(o_locked), 1);
    check("p3_timeout_sticky", 32'(o_timeout), 1);

    // Asynchronous reset while locked
    reset = 1'b1;
    #2;
    check("p4_rst_locked", 32'(o_locked), 0);
    check("p4_rst_timeout", 32'(o_timeout), 0);
    check("p4_rst_period", 32'(o_period), 0);
    check("p4_rst_high", 32'(o_high_time), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b0;
    idle_cycles(2);
    repeat (4) drive_cycle(4, 4, 1'b0);
    check("p4_not_locked_4", 32'(o_locked), 0);
    drive_cycle(4, 4, 1'b0);
    check("p4_locked_5", 32'(o_locked), 1);

    // Divide-by-8 checked against an expected ratio of 4
    i_en  = 1'b0;
    armed = 1'b0;
    idle_cycles(2);
    i_expected_ratio = 8'd4;
    i_en = 1'b1;
    idle_cycles(2);
    saw_lock = 1'b0;
    repeat (6) drive_cycle(4, 4, 1'b0);
    check("p5_never_locked", 32'(saw_lock), 0);
    check("p5_ratio_err", 32'(o_ratio_err), 0);
    check("p5_period", 32'(o_period), 8);

    // Enable dropped for 3 cycles while locked
    i_en  = 1'b0;
    armed = 1'b0;
    idle_cycles(2);
    i_expected_ratio = 8'd8;
    i_en = 1'b1;
    idle_cycles(2);
    repeat (5) drive_cycle(4, 4, 1'b0);
    check("p6_locked", 32'(o_locked), 1);
    i_en = 1'b0;
    idle_cycles(3);
    check("p6_dis_unlocked", 32'(o_locked), 0);
    check("p6_dis_period_held", 32'(o_period), 8);
    check("p6_dis_high_held", 32'(o_high_time), 4);
    i_en  = 1'b1;
    armed = 1'b0;
    idle_cycles(2);
    repeat (5) drive_cycle(4, 4, 1'b0);
    check("p6_relocked", 32'(o_locked), 1);
    // Clear pulse coincides with the mismatching rise: set wins
    drive_cycle(4, 5, 1'b0);
    drive_cycle(4, 4, 1'b1);
    check("p6_set_wins", 32'(o_ratio_err), 1);
    check("p6_unlocked", 32'(o_locked), 0);

    idle_cycles(2);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Consumer-side checker for divided clocks produced by the team's counter-based dividers, such as the divide-by-8 block.
- Samples a divided clock generated from `clk` and measures its period and high time in `clk` cycles.
- Declares lock after a run of periods matching a programmed ratio; flags ratio errors and loss of edges.
- Sits beside each divider instance as a built-in self-check.

Parameters:
- CNT_W, 8: width of the period/high-time counter; max measurable period is 2^CNT_W-1.
- LOCK_CNT, 4: consecutive matching periods required to assert lock (1..15).

Ports:
- clk  input  1  system clock; the divided clock is derived from it.
- reset  input  1  asynchronous, active-high reset.
- i_en  input  1  monitor enable.
- i_div_clk  input  1  divided clock under test, launched from a `clk` flop.
- i_expected_ratio  input  CNT_W  expected period in `clk` cycles; must be at least 2 and held stable while enabled.
- i_err_clr  input  1  clears the sticky error flags.
- o_period  output  CNT_W  last measured period.
- o_high_time  output  CNT_W  last measured high time.
- o_period_valid  output  1  one-cycle pulse when o_period updates.
- o_locked  output  1  ratio lock status.
- o_ratio_err  output  1  sticky: mismatch occurred while locked.
- o_timeout  output  1  sticky: no rising edge within 2^CNT_W-1 cycles.

Behaviour:
- Reset state: every output is 0; the counter, match count and div_q are 0; the FSM is in IDLE.
- Edge detection:
  - div_q is a registered copy of i_div_clk.
  - Rise = i_div_clk & ~div_q; fall = ~i_div_clk & div_q.
  - Both are evaluated combinationally on the sampled input, so detection has zero added latency relative to the `clk` edge that sees the new level.
- Counter:
  - On a rise it loads 1.
  - Otherwise it increments, saturating at 2^CNT_W-1.
  - In the cycle a rise is detected, the counter value equals the period (the divide-by-8 case gives 8).
- FSM states: IDLE, WAIT_EDGE, MEASURE, LOCKED.
  - IDLE → WAIT_EDGE when i_en=1 and i_expected_ratio>=2. Otherwise stay in IDLE.
  - WAIT_EDGE → MEASURE on the first rise. The counter starts; no period is reported for this edge.
  - MEASURE, on each rise:
    - o_period ← counter; o_period_valid pulses the next cycle, aligned with the new o_period.
    - On a match, match_cnt increments; otherwise match_cnt ← 0 and no error is raised.
    - When match_cnt reaches LOCK_CNT, go to LOCKED and set o_locked=1 in the same update.
  - LOCKED, on each rise:
    - Update o_period as in MEASURE.
    - On a mismatch, set o_ratio_err, clear o_locked and match_cnt, and return to MEASURE.
- High time: on a fall in MEASURE or LOCKED, o_high_time ← counter. A fall in WAIT_EDGE is ignored.
- Timeout: in MEASURE or LOCKED, when the counter is saturated and no rise is seen:
  - set o_timeout;
  - clear o_locked and match_cnt;
  - go to WAIT_EDGE.
- i_en=0 in any state:
  - go to IDLE next cycle;
  - clear o_locked, the counter and match_cnt;
  - hold o_period and o_high_time;
  - keep the sticky flags.
- Sticky flags: i_err_clr=1 clears o_ratio_err and o_timeout. If a set condition occurs in the same cycle, the set wins.
- A change to i_expected_ratio while enabled is unsupported. A stable value is required; the bench must not do this.
- Reset asserted mid-operation clears everything immediately (asynchronous). After release, the monitor restarts from IDLE and needs a fresh first edge.

Decomposition:
- Shared package clk_div_pkg:
  - FSM state typedef (2-bit encoding);
  - default CNT_W and LOCK_CNT constants;
  - saturation-max function.
- Sub-module clk_edge_detect: div_q register plus the rise/fall outputs. It is reusable by the other divider checkers.

Test Plan:
- Ideal divide-by-8 stream (4 high, 4 low), i_expected_ratio=8, LOCK_CNT=4 → o_period=8 and o_high_time=4 on every period; o_locked rises at the 5th rising edge; no flags set.
- After lock, stretch one low phase to 5 cycles (period 9) → o_period=9, o_ratio_err=1, o_locked=0; relocks after 4 further good periods; o_ratio_err stays 1 until an i_err_clr pulse clears it.
- After lock, hold i_div_clk low, CNT_W=8 → o_timeout=1 once the counter saturates at 255; o_locked=0; FSM in WAIT_EDGE; restarting the stream relocks.
- Divide-by-8 input with i_expected_ratio=4 → o_period=8 reported each period; o_locked is never set; o_ratio_err stays 0.
- Assert reset while locked → all outputs 0 asynchronously; after release the first rising edge produces no o_period_valid and lock returns after 5 rises.
- Drop i_en for 3 cycles while locked → o_locked=0, o_period held at 8; after i_en returns, the monitor relocks; i_err_clr coinciding with a mismatch leaves o_ratio_err=1.
